// File: rtl/rv32_pkg.sv
// rv32_pkg: shared fetch-stage types and constants
package rv32_pkg;
  typedef enum logic [1:0] {BOOT, REQ, WAIT, FULL} fetch_state_t;
  localparam logic [31:0] NOP_INST_C = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_C = 32'h0000_0000;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with stall hold and flush-to-bubble
module if_id_reg
  import rv32_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic [31:0] PC_ID,
  output logic [31:0] INST_ID,
  output logic        valid_ID
);
  logic take;
  assign take = load && !flush;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC_ID    <= '0;
      INST_ID  <= NOP_INST;
      valid_ID <= 1'b0;
    end else if (flush || !stall) begin
      PC_ID    <= take ? load_pc : '0;
      INST_ID  <= take ? load_inst : NOP_INST;
      valid_ID <= take;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch FSM with skid buffer and EX redirect
module fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_C,
  parameter logic [31:0] NOP_INST = NOP_INST_C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        PCSel_EX,
  input  logic [31:0] alu_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_ID,
  output logic [31:0] INST_ID,
  output logic        valid_ID
);
  fetch_state_t state;
  logic [31:0] pc_q, req_pc, buf_pc, buf_inst;
  logic discard, hit, load, keep;
  assign imem_req  = state == REQ;
  assign imem_addr = pc_q;
  assign hit  = state == WAIT && imem_rvalid && !discard;
  assign keep = hit && !PCSel_EX;
  assign load = !PCSel_EX && !stall && (hit || state == FULL);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pc_q     <= RESET_PC & ~32'h3;
      req_pc   <= '0;
      discard  <= 1'b0;
      buf_pc   <= '0;
      buf_inst <= NOP_INST;
    end else begin
      if (PCSel_EX) pc_q <= alu_target & ~32'h3;
      case (state)
        BOOT: state <= REQ;
        REQ: if (imem_gnt) begin
          req_pc  <= pc_q;
          discard <= PCSel_EX;
          state   <= WAIT;
        end
        WAIT: if (imem_rvalid) begin
          discard <= 1'b0;
          state   <= keep && stall ? FULL : REQ;
          if (keep) pc_q <= req_pc + 32'd4;
          if (keep && stall) begin
            buf_pc   <= req_pc;
            buf_inst <= imem_rdata;
          end
        end else if (PCSel_EX) discard <= 1'b1;
        FULL: if (PCSel_EX || !stall) state <= REQ;
        default: state <= BOOT;
      endcase
    end
  end
  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (PCSel_EX),
    .load     (load),
    .load_pc  (state == FULL ? buf_pc : req_pc),
    .load_inst(state == FULL ? buf_inst : imem_rdata),
    .PC_ID    (PC_ID),
    .INST_ID  (INST_ID),
    .valid_ID (valid_ID)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against hand-derived expectations
module tb_fetch_stage;
  import rv32_pkg::*;
  logic        clk = 0, rst = 1, stall = 0, PCSel_EX = 0;
  logic [31:0] alu_target = '0;
  logic        imem_req, imem_gnt = 1, imem_rvalid = 0;
  logic [31:0] imem_addr, imem_rdata = '0, PC_ID, INST_ID;
  logic        valid_ID, auto_rsp = 1;
  int n_cmp = 0, n_bad = 0;
  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .PCSel_EX(PCSel_EX), .alu_target(alu_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PC_ID(PC_ID), .INST_ID(INST_ID), .valid_ID(valid_ID)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic granted;
    logic [31:0] a;
    granted = imem_req && imem_gnt;
    a = imem_addr;
    @(posedge clk); #1;
    if (auto_rsp) begin
      imem_rvalid = granted;
      imem_rdata  = granted ? mem(a) : '0;
    end
  endtask
  task automatic if_id(input string tag, input logic [31:0] pc, input logic [31:0] inst, input logic v);
    check({tag, "_pc"}, PC_ID, pc);
    check({tag, "_inst"}, INST_ID, inst);
    check({tag, "_valid"}, {31'b0, valid_ID}, {31'b0, v});
  endtask
  initial begin
    @(posedge clk); @(posedge clk); #1;
    check("rst_req", {31'b0, imem_req}, 0);
    check("rst_addr", imem_addr, 32'h0);
    if_id("rst", 32'h0, 32'h13, 0);
    rst = 0;
    check("boot_req", {31'b0, imem_req}, 0);
    tick();
    check("req0_req", {31'b0, imem_req}, 1);
    check("req0_addr", imem_addr, 32'h0);
    tick();
    tick();
    if_id("f0", 32'h0, mem(32'h0), 1);
    check("req4_addr", imem_addr, 32'h4);
    tick();
    tick();
    if_id("f4", 32'h4, mem(32'h4), 1);
    check("req8_addr", imem_addr, 32'h8);
    stall = 1;
    tick();
    if_id("hold1", 32'h4, mem(32'h4), 1);
    tick();
    if_id("hold2", 32'h4, mem(32'h4), 1);
    check("full_state", 32'(dut.state), 32'(FULL));
    check("full_req", {31'b0, imem_req}, 0);
    tick();
    if_id("hold3", 32'h4, mem(32'h4), 1);
    stall = 0;
    tick();
    if_id("f8", 32'h8, mem(32'h8), 1);
    check("reqC_addr", imem_addr, 32'hC);
    tick();
    PCSel_EX = 1; alu_target = 32'h103;
    tick();
    PCSel_EX = 0;
    if_id("redir", 32'h0, 32'h13, 0);
    check("redir_addr", imem_addr, 32'h100);
    tick();
    tick();
    if_id("f100", 32'h100, mem(32'h100), 1);
    check("req104_addr", imem_addr, 32'h104);
    stall = 1; PCSel_EX = 1; alu_target = 32'h40;
    tick();
    stall = 0; PCSel_EX = 0;
    if_id("stflush", 32'h0, 32'h13, 0);
    tick();
    check("drop_valid", {31'b0, valid_ID}, 0);
    check("req40_req", {31'b0, imem_req}, 1);
    check("req40_addr", imem_addr, 32'h40);
    tick();
    rst = 1; #1;
    check("mid_rst_req", {31'b0, imem_req}, 0);
    check("mid_rst_addr", imem_addr, 32'h0);
    tick();
    rst = 0; auto_rsp = 0; imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = 32'hDEADBEEF;
    tick();
    if_id("late1", 32'h0, 32'h13, 0);
    check("late_req", {31'b0, imem_req}, 1);
    check("late_addr", imem_addr, 32'h0);
    tick();
    if_id("late2", 32'h0, 32'h13, 0);
    imem_rvalid = 0; auto_rsp = 1;
    PCSel_EX = 1; alu_target = 32'hFFFF_FFFE;
    tick();
    PCSel_EX = 0; imem_gnt = 1;
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    if_id("ftop", 32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 1);
    check("wrap_addr", imem_addr, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_INST, default 32'h0000_0013, which is the instruction driven into ID when no valid instruction is held.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port stall, input, 1 bit: load-use hold from the hazard logic; the IF_ID outputs must not change while it is high.
REQ-006 The block SHALL have port PCSel_EX, input, 1 bit: taken branch or jump resolved in EX, causing a redirect.
REQ-007 The block SHALL have port alu_target, input, 32 bits: redirect target from the EX ALU.
REQ-008 The block SHALL have port imem_req, output, 1 bit: instruction-memory request valid.
REQ-009 The block SHALL have port imem_addr, output, 32 bits: request address, word aligned.
REQ-010 The block SHALL have port imem_gnt, input, 1 bit: request accepted in the same cycle it is asserted.
REQ-011 The block SHALL have port imem_rvalid, input, 1 bit: read data valid, at least 1 cycle after the grant.
REQ-012 The block SHALL have port imem_rdata, input, 32 bits: fetched instruction.
REQ-013 The block SHALL have port PC_ID, output, 32 bits: PC of the instruction presented to ID.
REQ-014 The block SHALL have port INST_ID, output, 32 bits: instruction presented to ID.
REQ-015 The block SHALL have port valid_ID, output, 1 bit: INST_ID is a real fetched instruction rather than a bubble.

Function
REQ-016 The FSM SHALL have states BOOT, REQ, WAIT and FULL, with at most one memory request outstanding.
REQ-017 BOOT SHALL last exactly one cycle after reset release, then move to REQ; imem_req SHALL be 0 in BOOT.
REQ-018 In REQ the block SHALL drive imem_req=1 and imem_addr=pc_q.
- On imem_gnt it SHALL latch req_pc=pc_q and move to WAIT.
REQ-019 In WAIT, on imem_rvalid with stall=0 and discard=0, the block SHALL load the IF_ID outputs as PC_ID=req_pc, INST_ID=imem_rdata, valid_ID=1.
- It SHALL set pc_q=req_pc+4 (mod 2^32) and move to REQ.
REQ-020 In WAIT, on imem_rvalid with stall=1 and discard=0, the block SHALL capture the response into a one-entry skid buffer, set pc_q=req_pc+4, and move to FULL.
REQ-021 In FULL, the block SHALL hold the buffer while stall=1.
- On stall=0 it SHALL move the buffer into IF_ID with valid_ID=1 and go to REQ.
REQ-022 In any cycle in which stall=0 and no instruction is loaded, IF_ID SHALL take a bubble: PC_ID=0, INST_ID=NOP_INST, valid_ID=0.
REQ-023 While stall=1 and PCSel_EX=0, PC_ID, INST_ID and valid_ID SHALL hold their values.
REQ-024 A redirect (PCSel_EX=1) SHALL take priority over stall and over any response.
- It SHALL set pc_q={alu_target[31:2],2'b00}.
- It SHALL flush IF_ID to a bubble in the same edge.
REQ-025 A redirect in WAIT without imem_rvalid SHALL set discard=1.
- The next response SHALL then be dropped, discard cleared, and the FSM returned to REQ.
REQ-026 A redirect coincident with imem_rvalid SHALL drop that response and move to REQ.
REQ-027 A redirect in FULL SHALL drop the buffered instruction and move to REQ.
REQ-028 A redirect in REQ coincident with imem_gnt SHALL treat the granted request as stale: go to WAIT with discard=1.
REQ-029 imem_addr[1:0] SHALL always be 00.

Reset
REQ-030 While rst=1, the block SHALL force FSM=BOOT, pc_q=RESET_PC, req_pc=0, discard=0 and an empty skid buffer.
- It SHALL also force imem_req=0, imem_addr=RESET_PC, PC_ID=0, INST_ID=NOP_INST and valid_ID=0.
REQ-031 A reset asserted mid-operation SHALL abandon any outstanding request.
- Any imem_rvalid arriving after reset release but before the first new grant SHALL be ignored.

Structure
REQ-032 The shared package rv32_pkg SHALL hold the fetch_state_t enum, NOP_INST_C (32'h0000_0013) and RESET_PC_C, and the parameter defaults SHALL use them.
REQ-033 The IF_ID output register, including stall hold and flush-to-bubble, SHALL be a sub-module named if_id_reg.
- The FSM, pc_q, discard and skid buffer SHALL stay in fetch_stage.

Verification
REQ-034 Scenario: reset, then gnt always 1 and rvalid 1 cycle after grant.
- Required response: imem_addr sequence 0x0, 0x4, 0x8.
- Required response: PC_ID 0x0, 0x4, 0x8, with valid_ID=1 and INST_ID matching memory.
REQ-035 Scenario: stall=1 for 3 cycles while the response for 0x8 returns.
- Required response: IF_ID holds 0x4; FSM goes to FULL; imem_req=0.
- Required response: 0x8 appears exactly one cycle after stall falls.
REQ-036 Scenario: PCSel_EX=1 with alu_target=0x103 while in WAIT for 0xC.
- Required response: the 0xC response is dropped and IF_ID is a bubble (INST_ID=0x00000013).
- Required response: next imem_addr=0x100, and PC_ID=0x100 with valid_ID=1 follows.
REQ-037 Scenario: PCSel_EX=1 and stall=1 in the same cycle, target 0x40.
- Required response: IF_ID is flushed to a bubble, and the next request is 0x40.
REQ-038 Scenario: rst pulsed while in WAIT, then a late rvalid with rdata=0xDEADBEEF.
- Required response: the data is ignored and valid_ID stays 0.
- Required response: after BOOT, imem_addr=RESET_PC.
REQ-039 Scenario: pc_q=0xFFFF_FFFC fetched.
- Required response: the next imem_addr is 0x0000_0000 (wrap).
